// File: rtl/arbitrated_memory.sv
// -----------------------------------------------------------------------------
// arbitrated_memory
//
// Single-port memory shared by NUM_CH requesters through a round-robin
// arbiter. After reset the memory is cleared one entry per cycle (INIT),
// after which requests are served (RUN). At most one request is accepted per
// cycle. Writes complete at the accepting edge and produce no response. Reads
// return their data one cycle after acceptance through a single response
// register that is held until the consumer takes it.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset (restarts the memory clear)
//   req_valid  per-channel request valid
//   req_ready  per-channel accept, one-hot or zero
//   req_we     per-channel 1 = write, 0 = read
//   req_addr   per-channel address
//   req_wdata  per-channel write data
//   rsp_valid  read response valid
//   rsp_ready  response consumer ready
//   rsp_ch     channel that issued the returned read
//   rsp_rdata  read data
//   init_busy  memory clear in progress
// -----------------------------------------------------------------------------
module arbitrated_memory #(
  parameter type T      = logic [31:0],
  parameter int  DEPTH  = 256,
  parameter int  NUM_CH = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_we,
  input  logic [NUM_CH-1:0][AW-1:0]  req_addr,
  input  T                           req_wdata [NUM_CH],
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [CW-1:0]              rsp_ch,
  output T                           rsp_rdata,
  output logic                       init_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  // With a power-of-two depth every address is in range.
  localparam bit DEPTH_POW2 = (DEPTH == (1 << AW));

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   init_cnt_reg, init_cnt_next;
  logic [CW-1:0]   rr_ptr_reg, rr_ptr_next;

  logic            rsp_valid_reg;
  logic [CW-1:0]   rsp_ch_reg;
  T                rsp_rdata_reg;

  T                mem [DEPTH];

  logic            rsp_free;
  logic [NUM_CH-1:0] eligible;
  logic            grant_vld;
  logic [CW-1:0]   grant_idx;
  int              scan_idx;

  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  T                sel_wdata;
  logic            addr_ok;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  T                mem_wdata;
  logic            rd_en;

  // A read may only be accepted if the response register is empty or is being
  // drained on this same edge, which gives back-to-back responses.
  assign rsp_free = !rsp_valid_reg || rsp_ready;

  // Writes never depend on the response path, so a stalled read is simply not
  // eligible and cannot block a write further down the round-robin order.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
      assign eligible[gi] = req_valid[gi] && (req_we[gi] || rsp_free);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state, arbitration and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    init_busy     = 1'b0;
    grant_vld     = 1'b0;
    grant_idx     = '0;
    scan_idx      = 0;
    req_ready     = '0;

    case (state_reg)
      ST_INIT: begin
        init_busy     = 1'b1;
        init_cnt_next = init_cnt_reg + AW'(1);
        if (init_cnt_reg == LAST_IDX) begin
          state_next    = ST_RUN;
          init_cnt_next = '0;
        end
      end

      ST_RUN: begin
        // Scan channels starting at rr_ptr, wrapping modulo NUM_CH.
        for (int i = 0; i < NUM_CH; i++) begin
          scan_idx = int'(rr_ptr_reg) + i;
          if (scan_idx >= NUM_CH) begin
            scan_idx = scan_idx - NUM_CH;
          end
          if (!grant_vld && eligible[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = CW'(scan_idx);
          end
        end
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          if (int'(grant_idx) == NUM_CH - 1) begin
            rr_ptr_next = '0;
          end else begin
            rr_ptr_next = grant_idx + CW'(1);
          end
        end
      end

      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // Selected request fields of the granted channel.
  assign sel_we    = req_we[grant_idx];
  assign sel_addr  = req_addr[grant_idx];
  assign sel_wdata = req_wdata[grant_idx];
  assign addr_ok   = DEPTH_POW2 || (int'(sel_addr) < DEPTH);

  // Memory write port: the clear sequence owns it during INIT.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sel_addr;
    mem_wdata = sel_wdata;
    if (state_reg == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt_reg;
      mem_wdata = '0;
    end else if (grant_vld && sel_we && addr_ok) begin
      mem_we = 1'b1;
    end
  end

  assign rd_en = grant_vld && !sel_we;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
      rr_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
    end
  end

  // Memory array has no reset; its contents are defined by the clear sequence.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Response register: loaded by an accepted read, cleared when consumed,
  // otherwise held stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_ch_reg    <= '0;
      rsp_rdata_reg <= '0;
    end else if (rd_en) begin
      rsp_valid_reg <= 1'b1;
      rsp_ch_reg    <= grant_idx;
      rsp_rdata_reg <= addr_ok ? mem[sel_addr] : '0;
    end else if (rsp_valid_reg && rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_ch    = rsp_ch_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule
